// File: rtl/ipv4_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ipv4_tx_arbiter
// Purpose  : Packet-level round-robin arbiter that shares the single IPv4
//            transmit bus among NUM_PORTS layer-4 engines. The granted
//            port's fields are forwarded through a one-cycle register stage.
//            A watchdog forces a drop when a granted port goes silent.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   req                 : per-port level request
//   grant               : registered one-hot grant
//   in_start/in_data_valid/in_commit/in_drop : per-port bus strobes
//   in_bytes_valid      : per-port byte count (3 bits each)
//   in_data             : per-port 32-bit data word
//   in_payload_len      : per-port 16-bit L4 payload length
//   in_dst_ip           : per-port 32-bit destination address
//   in_protocol         : per-port 8-bit IP protocol number
//   out_*               : granted port's fields delayed by one cycle
//   err_ungranted       : pulse, a non-granted port strobed start/data/commit
//   timeout_count       : saturating count of watchdog drops
// ============================================================================
module ipv4_tx_arbiter #(
  parameter int NUM_PORTS      = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PORTS-1:0]      req,
  output logic [NUM_PORTS-1:0]      grant,
  input  logic [NUM_PORTS-1:0]      in_start,
  input  logic [NUM_PORTS-1:0]      in_data_valid,
  input  logic [NUM_PORTS-1:0]      in_commit,
  input  logic [NUM_PORTS-1:0]      in_drop,
  input  logic [3*NUM_PORTS-1:0]    in_bytes_valid,
  input  logic [32*NUM_PORTS-1:0]   in_data,
  input  logic [16*NUM_PORTS-1:0]   in_payload_len,
  input  logic [32*NUM_PORTS-1:0]   in_dst_ip,
  input  logic [8*NUM_PORTS-1:0]    in_protocol,
  output logic                      out_start,
  output logic                      out_data_valid,
  output logic                      out_commit,
  output logic                      out_drop,
  output logic [2:0]                out_bytes_valid,
  output logic [31:0]               out_data,
  output logic [15:0]               out_payload_len,
  output logic [31:0]               out_dst_ip,
  output logic [7:0]                out_protocol,
  output logic                      err_ungranted,
  output logic [31:0]               timeout_count
);

  localparam int c_ptr_w = $clog2(NUM_PORTS);
  localparam int c_wd_w  = $clog2(TIMEOUT_CYCLES + 1);
  // Watchdog fires in the cycle the counter would reach TIMEOUT_CYCLES.
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANTED = 2'd1,
    S_ACTIVE  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [NUM_PORTS-1:0]   r_grant;
  logic [c_ptr_w-1:0]     r_rr_ptr;
  logic [c_wd_w-1:0]      r_wd;
  logic                   r_out_start;
  logic                   r_out_dv;
  logic                   r_out_commit;
  logic                   r_out_drop;
  logic [2:0]             r_out_bv;
  logic [31:0]            r_out_data;
  logic [15:0]            r_out_len;
  logic [31:0]            r_out_dst;
  logic [7:0]             r_out_proto;
  logic                   r_err;
  logic [31:0]            r_timeout_count;

  // Granted port's inputs
  logic        w_g_req;
  logic        w_g_start;
  logic        w_g_dv;
  logic        w_g_commit;
  logic        w_g_drop;
  logic [2:0]  w_g_bv;
  logic [31:0] w_g_data;
  logic [15:0] w_g_len;
  logic [31:0] w_g_dst;
  logic [7:0]  w_g_proto;

  always_comb begin
    w_g_req    = 1'b0;
    w_g_start  = 1'b0;
    w_g_dv     = 1'b0;
    w_g_commit = 1'b0;
    w_g_drop   = 1'b0;
    w_g_bv     = '0;
    w_g_data   = '0;
    w_g_len    = '0;
    w_g_dst    = '0;
    w_g_proto  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant[i]) begin
        w_g_req    = req[i];
        w_g_start  = in_start[i];
        w_g_dv     = in_data_valid[i];
        w_g_commit = in_commit[i];
        w_g_drop   = in_drop[i];
        w_g_bv     = in_bytes_valid[3*i +: 3];
        w_g_data   = in_data[32*i +: 32];
        w_g_len    = in_payload_len[16*i +: 16];
        w_g_dst    = in_dst_ip[32*i +: 32];
        w_g_proto  = in_protocol[8*i +: 8];
      end
    end
  end

  // Round-robin pick: first requester at or above the pointer, otherwise
  // the lowest-numbered requester (the wrap-around case).
  logic                 w_found_hi;
  logic [c_ptr_w-1:0]   w_idx_hi;
  logic [c_ptr_w-1:0]   w_idx_lo;
  logic [c_ptr_w-1:0]   w_win_idx;
  logic [c_ptr_w-1:0]   w_next_ptr;
  logic [NUM_PORTS-1:0] w_win_oh;

  always_comb begin
    w_found_hi = 1'b0;
    w_idx_hi   = '0;
    w_idx_lo   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_idx_lo = c_ptr_w'(i);
        if (c_ptr_w'(i) >= r_rr_ptr) begin
          w_idx_hi   = c_ptr_w'(i);
          w_found_hi = 1'b1;
        end
      end
    end
    w_win_idx  = w_found_hi ? w_idx_hi : w_idx_lo;
    w_next_ptr = (w_win_idx == c_ptr_w'(NUM_PORTS - 1)) ? '0
                                                         : w_win_idx + c_ptr_w'(1);
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_win_oh[i] = (c_ptr_w'(i) == w_win_idx);
    end
  end

  logic w_g_act;
  logic w_timeout;
  logic w_err;

  assign w_g_act   = w_g_start | w_g_dv | w_g_commit | w_g_drop;
  assign w_timeout = (r_state != S_IDLE) && (r_wd == c_wd_last);
  assign w_err     = |((in_start | in_data_valid | in_commit) & ~r_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_grant         <= '0;
      r_rr_ptr        <= '0;
      r_wd            <= '0;
      r_out_start     <= 1'b0;
      r_out_dv        <= 1'b0;
      r_out_commit    <= 1'b0;
      r_out_drop      <= 1'b0;
      r_out_bv        <= '0;
      r_out_data      <= '0;
      r_out_len       <= '0;
      r_out_dst       <= '0;
      r_out_proto     <= '0;
      r_err           <= 1'b0;
      r_timeout_count <= '0;
    end else begin
      r_err        <= w_err;
      r_out_start  <= 1'b0;
      r_out_dv     <= 1'b0;
      r_out_commit <= 1'b0;
      r_out_drop   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wd <= '0;
          if (|req) begin
            r_grant  <= w_win_oh;
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_GRANTED;
          end
        end
        S_GRANTED, S_ACTIVE: begin
          if (w_timeout) begin
            // Forced drop wins; any same-cycle granted strobe is discarded.
            r_out_drop <= 1'b1;
            r_grant    <= '0;
            r_state    <= S_IDLE;
            r_wd       <= '0;
            if (r_timeout_count != 32'hFFFF_FFFF) begin
              r_timeout_count <= r_timeout_count + 32'd1;
            end
          end else begin
            r_out_start  <= w_g_start;
            r_out_dv     <= w_g_dv;
            r_out_commit <= w_g_commit;
            r_out_drop   <= w_g_drop;
            r_out_bv     <= w_g_bv;
            r_out_data   <= w_g_data;
            // Header fields only track the port while a packet is in flight.
            if (r_state == S_ACTIVE || w_g_start) begin
              r_out_len   <= w_g_len;
              r_out_dst   <= w_g_dst;
              r_out_proto <= w_g_proto;
            end
            r_wd <= w_g_act ? '0 : r_wd + c_wd_w'(1);
            if (w_g_commit || w_g_drop) begin
              r_grant <= '0;
              r_state <= S_IDLE;
            end else if (w_g_start) begin
              r_state <= S_ACTIVE;
            end else if (r_state == S_GRANTED && !w_g_req) begin
              // Requester abandoned before starting a packet.
              r_grant <= '0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_grant <= '0;
          r_wd    <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign grant           = r_grant;
  assign out_start       = r_out_start;
  assign out_data_valid  = r_out_dv;
  assign out_commit      = r_out_commit;
  assign out_drop        = r_out_drop;
  assign out_bytes_valid = r_out_bv;
  assign out_data        = r_out_data;
  assign out_payload_len = r_out_len;
  assign out_dst_ip      = r_out_dst;
  assign out_protocol    = r_out_proto;
  assign err_ungranted   = r_err;
  assign timeout_count   = r_timeout_count;

endmodule
`default_nettype wire
